bcd_display_scanner: RTL and testbench

//  Display-side consumer of the ALU result bus (dec_bin/unis_bin/zero/error).

---
 rtl/bcd_display_if.sv | 22 ++
 rtl/bcd_display_scanner.sv | 97 +++++++++
 tb/tb_bcd_display_scanner.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/bcd_display_if.sv
// bcd_display_if: ALU result bus from the producer to the display scanner, plus the
// scanner's ack and display drive.
interface bcd_display_if;
    logic       load;
    logic [3:0] dec_bin;
    logic [3:0] unis_bin;
    logic       zero;
    logic       error;
    logic       load_ack;
    logic [6:0] seg;
    logic [1:0] dig_en;

    modport master (
        output load, dec_bin, unis_bin, zero, error,
        input  load_ack, seg, dig_en
    );

    modport slave (
        input  load, dec_bin, unis_bin, zero, error,
        output load_ack, seg, dig_en
    );
endinterface

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: holds the last ALU result and time-multiplexes it onto a
// 2-digit 7-segment display, with error, invalid-digit and leading-zero rendering.
module bcd_display_scanner #(
    parameter int REFRESH_DIV    = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit BLANK_LEADING  = 1'b1
) (
    input logic          clk,
    input logic          rst_n,
    bcd_display_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SCAN_U = 2'd1;
    localparam logic [1:0] S_SCAN_T = 2'd2;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_MASK = {7{SEG_ACTIVE_LOW}};

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_dec;
    logic [3:0]    r_unis;
    logic          r_zero;
    logic          r_error;
    logic          r_ack;
    logic [6:0]    r_seg;
    logic [1:0]    r_dig;
    logic          w_tens;
    logic [3:0]    w_digit;
    logic [6:0]    w_glyph;
    logic [6:0]    w_seg;

    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0:    dec7 = 7'h3F;
            4'd1:    dec7 = 7'h06;
            4'd2:    dec7 = 7'h5B;
            4'd3:    dec7 = 7'h4F;
            4'd4:    dec7 = 7'h66;
            4'd5:    dec7 = 7'h6D;
            4'd6:    dec7 = 7'h7D;
            4'd7:    dec7 = 7'h07;
            4'd8:    dec7 = 7'h7F;
            4'd9:    dec7 = 7'h6F;
            default: dec7 = 7'h40;
        endcase
    endfunction

    // Glyph for the slot currently active; registered below so seg and dig_en flip together
    always_comb begin
        w_tens  = r_state == S_SCAN_T;
        w_digit = w_tens ? r_dec : r_unis;
        w_glyph = r_error ? (w_tens ? 7'h79 : 7'h50)
                : (w_digit > 4'd9) ? 7'h40
                : r_zero ? (w_tens ? 7'h00 : 7'h3F)
                : (w_tens && BLANK_LEADING && w_digit == 4'd0) ? 7'h00
                : dec7(w_digit);
        w_seg   = (r_state == S_IDLE ? 7'h00 : w_glyph) ^ SEG_MASK;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dec   <= '0;
            r_unis  <= '0;
            r_zero  <= 1'b0;
            r_error <= 1'b0;
            r_ack   <= 1'b0;
            r_seg   <= SEG_MASK;
            r_dig   <= 2'b00;
        end else begin
            r_ack <= bus.load;
            if (bus.load) begin
                r_dec   <= bus.dec_bin;
                r_unis  <= bus.unis_bin;
                r_zero  <= bus.zero;
                r_error <= bus.error;
            end
            r_seg <= w_seg;
            r_dig <= (r_state == S_IDLE) ? 2'b00 : {w_tens, ~w_tens};
            // A reload while scanning leaves the slot timing untouched
            if (r_state == S_IDLE) begin
                if (bus.load) r_state <= S_SCAN_U;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_state <= w_tens ? S_SCAN_U : S_SCAN_T;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.load_ack = r_ack;
    assign bus.seg      = r_seg;
    assign bus.dig_en   = r_dig;
endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: two parameter sets driven in lockstep and checked every cycle
// against a slot-timing model derived from the edge where scanning started.
module tb_bcd_display_scanner;
    localparam int RD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load = 1'b0;
    logic [3:0] dec = 4'd0;
    logic [3:0] unis = 4'd0;
    logic zero = 1'b0;
    logic err = 1'b0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    bcd_display_if b0 ();
    bcd_display_if b1 ();

    assign b0.load = load;
    assign b0.dec_bin = dec;
    assign b0.unis_bin = unis;
    assign b0.zero = zero;
    assign b0.error = err;
    assign b1.load = load;
    assign b1.dec_bin = dec;
    assign b1.unis_bin = unis;
    assign b1.zero = zero;
    assign b1.error = err;

    bcd_display_scanner #(.REFRESH_DIV(RD), .SEG_ACTIVE_LOW(1'b0), .BLANK_LEADING(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(b0.slave));
    bcd_display_scanner #(.REFRESH_DIV(RD), .SEG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave));

    wire [19:0] obs = {b0.seg, b0.dig_en, b0.load_ack, b1.seg, b1.dig_en, b1.load_ack};

    logic [6:0] DEC [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    int n_edge = 0;
    int e0 = -1;
    logic [3:0] h_dec = 4'd0;
    logic [3:0] h_unis = 4'd0;
    logic h_z = 1'b0;
    logic h_e = 1'b0;
    logic [19:0] exp_v;

    function automatic logic [6:0] glyph(bit tens, bit bl);
        logic [3:0] d = tens ? h_dec : h_unis;
        if (h_e) return tens ? 7'h79 : 7'h50;
        if (d > 9) return 7'h40;
        if (h_z) return tens ? 7'h00 : 7'h3F;
        if (tens && bl && d == 0) return 7'h00;
        return DEC[d];
    endfunction

    function automatic logic [9:0] view(bit sal, bit bl, logic ack);
        bit slot;
        if (e0 < 0) return {sal ? 7'h7F : 7'h00, 2'b00, ack};
        slot = (((n_edge - 1 - e0) / RD) % 2) == 1;
        return {glyph(slot, bl) ^ {7{sal}}, slot ? 2'b10 : 2'b01, ack};
    endfunction

    // Advance one clock; exp_v holds what both DUTs must show after this edge
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            exp_v = {7'h00, 2'b00, 1'b0, 7'h7F, 2'b00, 1'b0};
            e0 = -1;
            h_dec = 0; h_unis = 0; h_z = 0; h_e = 0;
        end else begin
            exp_v = {view(0, 1, load), view(1, 0, load)};
            if (load) begin
                h_dec = dec; h_unis = unis; h_z = zero; h_e = err;
                if (e0 < 0) e0 = n_edge;
            end
        end
        n_edge++;
        @(negedge clk);
    endtask

    task automatic set_in(logic l, logic [3:0] d, logic [3:0] u, logic z, logic e);
        load = l; dec = d; unis = u; zero = z; err = e;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(1, 4'd3, 4'd4, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL reset edge=%0d got=%h want=%h", n_edge, obs, exp_v); end
        end
        rst_n = 1'b1;
        set_in(0, 4'd3, 4'd4, 0, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL idle edge=%0d got=%h want=%h", n_edge, obs, exp_v); end
        end
    endtask

    task automatic test_scan();
        set_in(1, 4'd1, 4'd5, 0, 0);
        for (int i = 0; i < 4 * RD + 3; i++) begin
            tick();
            load = 1'b0;
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL scan edge=%0d got=%h want=%h", n_edge, obs, exp_v); end
        end
    endtask

    task automatic test_glyphs();
        logic [9:0] vec [8] = '{{4'd0, 4'd7, 2'b00}, {4'd9, 4'd9, 2'b01}, {4'd12, 4'd9, 2'b00},
                                {4'd0, 4'd0, 2'b10}, {4'd3, 4'd12, 2'b10}, {4'd5, 4'd0, 2'b10},
                                {4'd15, 4'd15, 2'b00}, {4'd0, 4'd11, 2'b01}};
        for (int v = 0; v < 8; v++) begin
            set_in(1, vec[v][9:6], vec[v][5:2], vec[v][1], vec[v][0]);
            for (int i = 0; i < 2 * RD + 1; i++) begin
                tick();
                load = 1'b0;
                total++;
                if (obs !== exp_v) begin bad++; $display("FAIL glyph v=%0d edge=%0d got=%h want=%h", v, n_edge, obs, exp_v); end
            end
        end
    endtask

    task automatic test_midslot();
        for (int i = 0; i < 2 * RD && ((n_edge - 1 - e0) % RD) != 2; i++) tick();
        set_in(1, 4'd8, 4'd2, 0, 0);
        for (int i = 0; i < 2 * RD + 2; i++) begin
            tick();
            load = 1'b0;
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL midslot edge=%0d got=%h want=%h", n_edge, obs, exp_v); end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            set_in(i < 7, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom_range(0, 3) == 0));
            tick();
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL b2b edge=%0d got=%h want=%h", n_edge, obs, exp_v); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 4) == 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
            tick();
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL random edge=%0d got=%h want=%h", n_edge, obs, exp_v); end
        end
    endtask

    task automatic test_reset_mid();
        set_in(1, 4'd4, 4'd2, 0, 0);
        rst_n = 1'b0;
        tick();
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL rstmid edge=%0d got=%h want=%h", n_edge, obs, exp_v); end
        rst_n = 1'b1;
        set_in(0, 4'd4, 4'd2, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL rstidle edge=%0d got=%h want=%h", n_edge, obs, exp_v); end
        end
        set_in(1, 4'd6, 4'd0, 0, 0);
        for (int i = 0; i < 2 * RD + 2; i++) begin
            tick();
            load = 1'b0;
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL rescan edge=%0d got=%h want=%h", n_edge, obs, exp_v); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_glyphs();
        test_midslot();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
